// File: rtl/axi_crossbar_admit_if.sv
// Address-request / routed-command / completion bundle for one crossbar slave port.
// The admit block uses the slave modport; the stimulus or upstream logic uses master.
interface axi_crossbar_admit_if #(
  parameter int ID_WIDTH   = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int M_COUNT    = 4
);
  localparam int CL_M_COUNT = M_COUNT > 1 ? $clog2(M_COUNT) : 1;

  logic [ID_WIDTH-1:0]   s_axi_aid;
  logic [ADDR_WIDTH-1:0] s_axi_aaddr;
  logic [2:0]            s_axi_aprot;
  logic                  s_axi_avalid;
  logic                  s_axi_aready;

  logic [3:0]            m_axi_aregion;
  logic [CL_M_COUNT-1:0] m_select;
  logic                  m_axi_avalid;
  logic                  m_axi_aready;

  logic [CL_M_COUNT-1:0] m_wc_select;
  logic                  m_wc_decerr;
  logic                  m_wc_valid;
  logic                  m_wc_ready;

  logic                  m_rc_decerr;
  logic                  m_rc_valid;
  logic                  m_rc_ready;

  logic [ID_WIDTH-1:0]   s_cpl_id;
  logic [CL_M_COUNT-1:0] s_cpl_m;
  logic                  s_cpl_valid;

  modport slave (
    input  s_axi_aid, s_axi_aaddr, s_axi_aprot, s_axi_avalid,
    output s_axi_aready,
    output m_axi_aregion, m_select, m_axi_avalid,
    input  m_axi_aready,
    output m_wc_select, m_wc_decerr, m_wc_valid,
    input  m_wc_ready,
    output m_rc_decerr, m_rc_valid,
    input  m_rc_ready,
    input  s_cpl_id, s_cpl_m, s_cpl_valid
  );

  modport master (
    output s_axi_aid, s_axi_aaddr, s_axi_aprot, s_axi_avalid,
    input  s_axi_aready,
    input  m_axi_aregion, m_select, m_axi_avalid,
    output m_axi_aready,
    input  m_wc_select, m_wc_decerr, m_wc_valid,
    output m_wc_ready,
    input  m_rc_decerr, m_rc_valid,
    output m_rc_ready,
    output s_cpl_id, s_cpl_m, s_cpl_valid
  );
endinterface

// File: rtl/axi_crossbar_admit.sv
// Crossbar slave-side address decode and admission control with one registered output stage.
// Define AXI_CROSSBAR_ADMIT_MISSUE_EN to enable per-master outstanding limits (M_ISSUE).
module axi_crossbar_admit #(
  parameter int S          = 0,
  parameter int S_COUNT    = 4,
  parameter int M_COUNT    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 8,
  parameter int S_THREADS  = 2,
  parameter int S_ACCEPT   = 16,
  parameter logic [M_COUNT*32-1:0] M_ISSUE = {M_COUNT{32'd4}},
  parameter int M_REGIONS  = 1,
  parameter logic [M_COUNT*M_REGIONS*ADDR_WIDTH-1:0] M_BASE_ADDR = '0,
  parameter logic [M_COUNT*M_REGIONS*32-1:0] M_ADDR_WIDTH = {M_COUNT*M_REGIONS{32'd24}},
  parameter logic [M_COUNT*S_COUNT-1:0] M_CONNECT = {M_COUNT*S_COUNT{1'b1}},
  parameter logic [M_COUNT-1:0] M_SECURE = '0,
  parameter int WC_OUTPUT  = 0
) (
  input logic clk,
  input logic rst,
  axi_crossbar_admit_if.slave bus
);
  localparam int CL_M_COUNT = M_COUNT > 1 ? $clog2(M_COUNT) : 1;
  localparam int TH = S_THREADS < S_ACCEPT ? S_THREADS : S_ACCEPT;
  localparam int TW = TH > 1 ? $clog2(TH) : 1;
  localparam int CW = $clog2(S_ACCEPT + 1);
  localparam int NR = M_COUNT * M_REGIONS;

  // Auto-pack: each region is aligned to its own size, placed after the previous one.
  function automatic logic [NR*ADDR_WIDTH-1:0] calc_base();
    logic [NR*ADDR_WIDTH-1:0] b;
    logic [63:0] base, step;
    int w;
    b    = '0;
    base = '0;
    for (int i = 0; i < NR; i++) begin
      w = int'(M_ADDR_WIDTH[i*32 +: 32]);
      if (w > 0) begin
        step = 64'd1 << w;
        base = (base + step - 64'd1) & ~(step - 64'd1);
        b[i*ADDR_WIDTH +: ADDR_WIDTH] = base[ADDR_WIDTH-1:0];
        base = base + step;
      end
    end
    return b;
  endfunction

  localparam logic [NR*ADDR_WIDTH-1:0] BASE = (M_BASE_ADDR == '0) ? calc_base() : M_BASE_ADDR;

  // ---- decode ----
  logic [NR-1:0]         rmatch;
  logic                  dec_hit;
  logic [CL_M_COUNT-1:0] sel_m;
  logic [3:0]            sel_r;

  for (genvar g = 0; g < NR; g++) begin : g_dec
    localparam int W  = int'(M_ADDR_WIDTH[g*32 +: 32]);
    localparam int MI = g / M_REGIONS;
    localparam logic [ADDR_WIDTH-1:0] B = BASE[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign rmatch[g] = (W != 0) && M_CONNECT[S + MI*S_COUNT] &&
                       (!bus.s_axi_aprot[1] || !M_SECURE[MI]) &&
                       (W >= ADDR_WIDTH || ((bus.s_axi_aaddr ^ B) >> W) == '0);
  end

  always_comb begin
    dec_hit = 1'b0;
    sel_m   = '0;
    sel_r   = '0;
    for (int g = 0; g < NR; g++) begin
      if (rmatch[g] && !dec_hit) begin
        dec_hit = 1'b1;
        sel_m   = CL_M_COUNT'(g / M_REGIONS);
        sel_r   = 4'(g % M_REGIONS);
      end
    end
  end

  // ---- thread tracking ----
  logic [ID_WIDTH-1:0]   th_id  [TH];
  logic [CL_M_COUNT-1:0] th_m   [TH];
  logic [3:0]            th_r   [TH];
  logic [CW-1:0]         th_cnt [TH];
  logic [CW-1:0]         trans_count;

  logic          id_hit, free_found, cpl_hit, cpl_en;
  logic [TW-1:0] hit_idx, free_idx, cpl_idx, th_sel;
  logic          thread_ok, accept_ok, issue_ok, admit, stage_free, aready, start;

  always_comb begin
    id_hit     = 1'b0;
    free_found = 1'b0;
    cpl_hit    = 1'b0;
    hit_idx    = '0;
    free_idx   = '0;
    cpl_idx    = '0;
    for (int t = 0; t < TH; t++) begin
      if (th_cnt[t] != '0 && th_id[t] == bus.s_axi_aid && !id_hit) begin
        id_hit  = 1'b1;
        hit_idx = TW'(t);
      end
      if (th_cnt[t] == '0 && !free_found) begin
        free_found = 1'b1;
        free_idx   = TW'(t);
      end
      if (th_cnt[t] != '0 && th_id[t] == bus.s_cpl_id && !cpl_hit) begin
        cpl_hit = 1'b1;
        cpl_idx = TW'(t);
      end
    end
  end

  // Completions for IDs with no live thread are dropped so nothing can underflow.
  assign cpl_en    = bus.s_cpl_valid && cpl_hit;
  // A busy ID may only reuse its thread toward the same destination; otherwise wait for drain.
  assign thread_ok = id_hit ? (th_m[hit_idx] == sel_m && th_r[hit_idx] == sel_r) : free_found;
  assign th_sel    = id_hit ? hit_idx : free_idx;
  assign accept_ok = (trans_count < CW'(S_ACCEPT)) || cpl_en;

`ifdef AXI_CROSSBAR_ADMIT_MISSUE_EN
  logic [CW-1:0] m_cnt [M_COUNT];

  assign issue_ok = (32'(m_cnt[sel_m]) < M_ISSUE[sel_m*32 +: 32]) ||
                    (cpl_en && bus.s_cpl_m == sel_m);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int m = 0; m < M_COUNT; m++) m_cnt[m] <= '0;
    end else begin
      for (int m = 0; m < M_COUNT; m++) begin
        if ((start && sel_m == CL_M_COUNT'(m)) &&
            !(cpl_en && bus.s_cpl_m == CL_M_COUNT'(m) && m_cnt[m] != '0))
          m_cnt[m] <= m_cnt[m] + 1'b1;
        else if (!(start && sel_m == CL_M_COUNT'(m)) &&
                 (cpl_en && bus.s_cpl_m == CL_M_COUNT'(m) && m_cnt[m] != '0))
          m_cnt[m] <= m_cnt[m] - 1'b1;
      end
    end
  end

  logic unused_cfg;
  assign unused_cfg = &{1'b0, bus.s_axi_aprot[0], bus.s_axi_aprot[2]};
`else
  assign issue_ok = 1'b1;

  logic unused_cfg;
  assign unused_cfg = &{1'b0, bus.s_axi_aprot[0], bus.s_axi_aprot[2], bus.s_cpl_m, M_ISSUE[0]};
`endif

  assign admit      = thread_ok && accept_ok && issue_ok;
  assign stage_free = (!bus.m_axi_avalid || bus.m_axi_aready) &&
                      (!bus.m_wc_valid   || bus.m_wc_ready) &&
                      (!bus.m_rc_valid   || bus.m_rc_ready);
  // Decode errors never touch the counters, so they bypass admission.
  assign aready     = !rst && bus.s_axi_avalid && stage_free && (!dec_hit || admit);
  assign start      = aready && dec_hit;
  assign bus.s_axi_aready = aready;

  always_ff @(posedge clk) begin
    if (rst) begin
      trans_count <= '0;
      for (int t = 0; t < TH; t++) th_cnt[t] <= '0;
    end else begin
      if (start && !cpl_en)      trans_count <= trans_count + 1'b1;
      else if (!start && cpl_en) trans_count <= trans_count - 1'b1;
      for (int t = 0; t < TH; t++) begin
        if ((start && th_sel == TW'(t)) && !(cpl_en && cpl_idx == TW'(t)))
          th_cnt[t] <= th_cnt[t] + 1'b1;
        else if (!(start && th_sel == TW'(t)) && (cpl_en && cpl_idx == TW'(t)))
          th_cnt[t] <= th_cnt[t] - 1'b1;
        if (start && th_sel == TW'(t)) begin
          th_id[t] <= bus.s_axi_aid;
          th_m[t]  <= sel_m;
          th_r[t]  <= sel_r;
        end
      end
    end
  end

  // ---- output stage ----
  logic [CL_M_COUNT-1:0] sel_q;
  logic [3:0]            reg_q;
  logic                  decerr_q, av_q, wc_q, rc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q    <= '0;
      reg_q    <= '0;
      decerr_q <= 1'b0;
      av_q     <= 1'b0;
      wc_q     <= 1'b0;
      rc_q     <= 1'b0;
    end else if (aready) begin
      sel_q    <= sel_m;
      reg_q    <= sel_r;
      decerr_q <= !dec_hit;
      av_q     <= dec_hit;
      wc_q     <= (WC_OUTPUT != 0);
      rc_q     <= !dec_hit;
    end else begin
      if (bus.m_axi_aready) av_q <= 1'b0;
      if (bus.m_wc_ready)   wc_q <= 1'b0;
      if (bus.m_rc_ready)   rc_q <= 1'b0;
    end
  end

  assign bus.m_select      = sel_q;
  assign bus.m_wc_select   = sel_q;
  assign bus.m_axi_aregion = reg_q;
  assign bus.m_wc_decerr   = decerr_q;
  assign bus.m_rc_decerr   = decerr_q;
  assign bus.m_axi_avalid  = av_q;
  assign bus.m_wc_valid    = wc_q;
  assign bus.m_rc_valid    = rc_q;
endmodule
